tx_block_gearbox: RTL and testbench

- Parametrised TX gearbox that converts 66-bit 64b/66b blocks (2-bit header plus 64-bit payload) from the PCS into a continuous DATA_WIDTH-bit transceiver word stream.
- Replaces the transceiver's external-gearbox sequence interface, so the MAC/PCS runs against raw-mode transceivers at 16-, 32- or 64-bit user width.
- Sits between the PCS scrambler output and the transceiver TX user data port, in the transceiver TX user clock domain.

---
 rtl/tx_block_gearbox.sv | 120 ++++++++++++
 tb/tb_tx_block_gearbox.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_block_gearbox.sv
// TX gearbox: packs 66-bit 64b/66b blocks into a continuous DATA_WIDTH-bit word stream.
// Optional block/underflow counters are built when TX_GEARBOX_STATS_EN is defined.
module tx_block_gearbox #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [63:0]           i_tx_data,
    input  logic [1:0]            i_tx_header,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_xver_data,
    output logic                  o_xver_data_valid,
    output logic                  o_underflow
`ifdef TX_GEARBOX_STATS_EN
    ,
    output logic [31:0]           o_block_count,
    output logic [15:0]           o_underflow_count
`endif
);

    localparam int BLK_BITS = 66;
    localparam int BUF_BITS = BLK_BITS + DATA_WIDTH;
    localparam int CW       = $clog2(BUF_BITS + 1);

    generate
        if (DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("tx_block_gearbox: DATA_WIDTH must be 16, 32 or 64");
        end
    endgenerate

    logic [BUF_BITS-1:0]   buf_q;
    logic [BUF_BITS-1:0]   buf_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [DATA_WIDTH-1:0] xver_data_q;
    logic [DATA_WIDTH-1:0] xver_data_d;
    logic                  xver_valid_q;
    logic                  xver_valid_d;
    logic                  underflow_q;
    logic                  underflow_d;
    logic                  run_q;
    logic                  run_d;

    logic                  out;
    logic                  accept;
    logic                  ready;
    logic [CW-1:0]         rem;
    logic [BUF_BITS-1:0]   remain_bits;
    logic [BUF_BITS-1:0]   blk_ext;

    always_comb begin
        out         = (cnt_q >= CW'(DATA_WIDTH));
        rem         = out ? (cnt_q - CW'(DATA_WIDTH)) : cnt_q;
        remain_bits = out ? (buf_q >> DATA_WIDTH) : buf_q;
        ready       = ((int'(rem) + BLK_BITS) <= BUF_BITS) && !i_reset;
        accept      = i_tx_valid && ready;
        // Gate the block by accept so idle/X inputs never reach the buffer.
        blk_ext     = accept ? BUF_BITS'({i_tx_data, i_tx_header}) : '0;
        buf_d       = remain_bits | (blk_ext << rem);
        cnt_d       = rem + (accept ? CW'(BLK_BITS) : CW'(0));
        xver_data_d = out ? buf_q[DATA_WIDTH-1:0] : xver_data_q;
        xver_valid_d = out;
        run_d       = run_q | out;
        underflow_d = run_q && !out;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            buf_q        <= '0;
            cnt_q        <= '0;
            xver_data_q  <= '0;
            xver_valid_q <= 1'b0;
            underflow_q  <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            xver_data_q  <= xver_data_d;
            xver_valid_q <= xver_valid_d;
            underflow_q  <= underflow_d;
            run_q        <= run_d;
        end
    end

    assign o_tx_ready        = ready;
    assign o_xver_data       = xver_data_q;
    assign o_xver_data_valid = xver_valid_q;
    assign o_underflow       = underflow_q;

`ifdef TX_GEARBOX_STATS_EN
    logic [31:0] block_count_q;
    logic [31:0] block_count_d;
    logic [15:0] underflow_count_q;
    logic [15:0] underflow_count_d;

    // Underflow counter tracks the registered flag cycle-for-cycle and saturates.
    always_comb begin
        block_count_d     = block_count_q + (accept ? 32'd1 : 32'd0);
        underflow_count_d = underflow_count_q;
        if (underflow_d && underflow_count_q != 16'hFFFF) begin
            underflow_count_d = underflow_count_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            block_count_q     <= '0;
            underflow_count_q <= '0;
        end else begin
            block_count_q     <= block_count_d;
            underflow_count_q <= underflow_count_d;
        end
    end

    assign o_block_count     = block_count_q;
    assign o_underflow_count = underflow_count_q;
`endif

endmodule

// File: tb/tb_tx_block_gearbox.sv
// Testbench for tx_block_gearbox: bit-level scoreboard across 16/32/64-bit instances.
module tb_tx_block_gearbox;

    logic        clk;
    logic        rst;

    logic [63:0] d16, d32, d64;
    logic [1:0]  h16, h32, h64;
    logic        v16, v32, v64;
    logic        r16, r32, r64;
    logic [15:0] x16;
    logic [31:0] x32;
    logic [63:0] x64;
    logic        xv16, xv32, xv64;
    logic        u16, u32, u64;
`ifdef TX_GEARBOX_STATS_EN
    logic [31:0] bc16, bc32, bc64;
    logic [15:0] uc16, uc32, uc64;
`endif

    bit q16[$];
    bit q32[$];
    bit q64[$];
    bit a16, a32, a64;

    int n_cmp = 0;
    int n_bad = 0;

    tx_block_gearbox #(.DATA_WIDTH(16)) dut16 (
        .i_clk(clk), .i_reset(rst), .i_tx_data(d16), .i_tx_header(h16),
        .i_tx_valid(v16), .o_tx_ready(r16), .o_xver_data(x16),
        .o_xver_data_valid(xv16), .o_underflow(u16)
`ifdef TX_GEARBOX_STATS_EN
        , .o_block_count(bc16), .o_underflow_count(uc16)
`endif
    );

    tx_block_gearbox #(.DATA_WIDTH(32)) dut (
        .i_clk(clk), .i_reset(rst), .i_tx_data(d32), .i_tx_header(h32),
        .i_tx_valid(v32), .o_tx_ready(r32), .o_xver_data(x32),
        .o_xver_data_valid(xv32), .o_underflow(u32)
`ifdef TX_GEARBOX_STATS_EN
        , .o_block_count(bc32), .o_underflow_count(uc32)
`endif
    );

    tx_block_gearbox #(.DATA_WIDTH(64)) dut64 (
        .i_clk(clk), .i_reset(rst), .i_tx_data(d64), .i_tx_header(h64),
        .i_tx_valid(v64), .o_tx_ready(r64), .o_xver_data(x64),
        .o_xver_data_valid(xv64), .o_underflow(u64)
`ifdef TX_GEARBOX_STATS_EN
        , .o_block_count(bc64), .o_underflow_count(uc64)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; accepted blocks are pushed bit-serially to the scoreboards.
    task automatic tick();
        bit [65:0] b;
        #1;
        a16 = 1'b0;
        a32 = 1'b0;
        a64 = 1'b0;
        if (v16 === 1'b1 && r16 === 1'b1) begin
            b = {d16, h16};
            for (int i = 0; i < 66; i++) q16.push_back(b[i]);
            a16 = 1'b1;
        end
        if (v32 === 1'b1 && r32 === 1'b1) begin
            b = {d32, h32};
            for (int i = 0; i < 66; i++) q32.push_back(b[i]);
            a32 = 1'b1;
        end
        if (v64 === 1'b1 && r64 === 1'b1) begin
            b = {d64, h64};
            for (int i = 0; i < 66; i++) q64.push_back(b[i]);
            a64 = 1'b1;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q16.delete();
            q32.delete();
            q64.delete();
        end
    endtask

    function automatic logic [63:0] pop_w(int w);
        logic [63:0] r;
        r = '0;
        case (w)
            16: if (q16.size() < 16) r = 'x;
                else for (int i = 0; i < 16; i++) r[i] = q16.pop_front();
            32: if (q32.size() < 32) r = 'x;
                else for (int i = 0; i < 32; i++) r[i] = q32.pop_front();
            default: if (q64.size() < 64) r = 'x;
                else for (int i = 0; i < 64; i++) r[i] = q64.pop_front();
        endcase
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        v16 = 1'b0;
        v32 = 1'b0;
        v64 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v16 = 1'b0;
        v32 = 1'b1;
        v64 = 1'b0;
        d32 = 64'hDEAD_BEEF_0000_1111;
        h32 = 2'b01;
        tick();
        tick();
        #1;
        n_cmp++;
        if (r32 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready32 got %b want 0", r32);
        end
        n_cmp++;
        if (r16 !== 1'b0 || r64 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready16_64 got %b/%b want 0/0", r16, r64);
        end
        n_cmp++;
        if (x32 !== 32'h0 || xv32 !== 1'b0 || u32 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got data=%h v=%b uf=%b want 0/0/0", x32, xv32, u32);
        end
        v32 = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (r32 !== 1'b1) begin
            n_bad++;
            $display("FAIL release_ready got %b want 1", r32);
        end
    endtask

    task automatic test_latency();
        logic [63:0] d;
        logic [63:0] e;
        do_reset();
        d   = 64'h0123_4567_89AB_CDEF;
        d32 = d;
        h32 = 2'b01;
        v32 = 1'b1;
        tick();
        v32 = 1'b0;
        n_cmp++;
        if (xv32 !== 1'b0) begin
            n_bad++;
            $display("FAIL lat_cycle1 valid got %b want 0", xv32);
        end
        tick();
        e = pop_w(32);
        n_cmp++;
        if (xv32 !== 1'b1 || x32 !== {d[29:0], 2'b01} || x32 !== e[31:0]) begin
            n_bad++;
            $display("FAIL lat_cycle2 got v=%b %h want v=1 %h", xv32, x32, {d[29:0], 2'b01});
        end
        tick();
        e = pop_w(32);
        n_cmp++;
        if (xv32 !== 1'b1 || x32 !== d[61:30] || x32 !== e[31:0]) begin
            n_bad++;
            $display("FAIL lat_cycle3 got v=%b %h want v=1 %h", xv32, x32, d[61:30]);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (xv32 !== 1'b0 || u32 !== 1'b1 || x32 !== d[61:30]) begin
                n_bad++;
                $display("FAIL lat_starve got v=%b uf=%b %h want v=0 uf=1 %h",
                         xv32, u32, x32, d[61:30]);
            end
        end
    endtask

    task automatic test_stream32();
        bit acc[200];
        bit started;
        int sum;
        logic [63:0] e;
        do_reset();
        started = 1'b0;
        v32 = 1'b1;
        for (int c = 0; c < 200; c++) begin
            d32 = {$urandom, $urandom};
            h32 = 2'($urandom_range(0, 3));
            tick();
            acc[c] = a32;
            if (xv32 === 1'b1) begin
                started = 1'b1;
                e = pop_w(32);
                n_cmp++;
                if (x32 !== e[31:0]) begin
                    n_bad++;
                    $display("FAIL stream32_word cyc=%0d got %h want %h", c, x32, e[31:0]);
                end
            end else if (started) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stream32_gap cyc=%0d got valid 0 want 1", c);
            end
        end
        v32 = 1'b0;
        for (int w = 10; w <= 130; w += 40) begin
            sum = 0;
            for (int k = 0; k < 66; k++) sum += int'(acc[w+k]);
            n_cmp++;
            if (sum != 32) begin
                n_bad++;
                $display("FAIL stream32_rate start=%0d got %0d want 32", w, sum);
            end
        end
    endtask

    task automatic test_starvation();
        int nacc;
        int nwords;
        int guard;
        bit seen;
        logic [63:0] last;
        logic [63:0] e;
        do_reset();
        nacc   = 0;
        nwords = 0;
        guard  = 0;
        seen   = 1'b0;
        last   = '0;
        v32 = 1'b1;
        while (nacc < 4 && guard < 40) begin
            d32 = {$urandom, $urandom};
            h32 = 2'($urandom_range(0, 3));
            tick();
            guard++;
            if (a32) begin
                nacc++;
                last = d32;
            end
            if (xv32 === 1'b1) begin
                nwords++;
                seen = 1'b1;
                e = pop_w(32);
                n_cmp++;
                if (x32 !== e[31:0]) begin
                    n_bad++;
                    $display("FAIL starve_word got %h want %h", x32, e[31:0]);
                end
            end
        end
        v32 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (xv32 === 1'b1) begin
                nwords++;
                seen = 1'b1;
                e = pop_w(32);
                n_cmp++;
                if (x32 !== e[31:0]) begin
                    n_bad++;
                    $display("FAIL starve_word got %h want %h", x32, e[31:0]);
                end
            end else if (seen) begin
                n_cmp++;
                if (u32 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL starve_underflow cyc=%0d got %b want 1", c, u32);
                end
            end
        end
        n_cmp++;
        if (nacc != 4 || nwords != 8) begin
            n_bad++;
            $display("FAIL starve_count got acc=%0d words=%0d want 4/8", nacc, nwords);
        end
        n_cmp++;
        if (q32.size() != 8) begin
            n_bad++;
            $display("FAIL starve_residue got %0d bits want 8", q32.size());
        end
        v32 = 1'b1;
        d32 = {$urandom, $urandom};
        h32 = 2'b10;
        tick();
        v32 = 1'b0;
        guard = 0;
        while (xv32 !== 1'b1 && guard < 6) begin
            tick();
            guard++;
        end
        e = pop_w(32);
        n_cmp++;
        if (xv32 !== 1'b1 || x32[7:0] !== last[63:56] || x32 !== e[31:0]) begin
            n_bad++;
            $display("FAIL starve_resume got v=%b %h want low byte %h word %h",
                     xv32, x32, last[63:56], e[31:0]);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        logic [63:0] d;
        logic [63:0] e;
        do_reset();
        v32 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            d32 = {$urandom, $urandom};
            h32 = 2'($urandom_range(0, 3));
            tick();
            if (xv32 === 1'b1) begin
                e = pop_w(32);
                n_cmp++;
                if (x32 !== e[31:0]) begin
                    n_bad++;
                    $display("FAIL mid_word got %h want %h", x32, e[31:0]);
                end
            end
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (r32 !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_ready got %b want 0", r32);
        end
        tick();
        rst = 1'b0;
        v32 = 1'b0;
        n_cmp++;
        if (x32 !== 32'h0 || xv32 !== 1'b0 || u32 !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_outputs got %h v=%b uf=%b want 0/0/0", x32, xv32, u32);
        end
        d   = {$urandom, $urandom};
        d32 = d;
        h32 = 2'b10;
        v32 = 1'b1;
        tick();
        v32 = 1'b0;
        guard = 0;
        while (xv32 !== 1'b1 && guard < 6) begin
            tick();
            guard++;
        end
        e = pop_w(32);
        n_cmp++;
        if (xv32 !== 1'b1 || x32 !== {d[29:0], 2'b10} || x32 !== e[31:0]) begin
            n_bad++;
            $display("FAIL mid_first got v=%b %h want %h", xv32, x32, {d[29:0], 2'b10});
        end
    endtask

    task automatic test_width_sweep();
        bit acc16[200];
        bit acc64[200];
        bit s16, s64;
        int sum;
        logic [63:0] e;
        do_reset();
        s16 = 1'b0;
        s64 = 1'b0;
        v16 = 1'b1;
        v64 = 1'b1;
        for (int c = 0; c < 200; c++) begin
            d16 = {$urandom, $urandom};
            h16 = 2'($urandom_range(0, 3));
            d64 = {$urandom, $urandom};
            h64 = 2'($urandom_range(0, 3));
            tick();
            acc16[c] = a16;
            acc64[c] = a64;
            if (s16 || xv16 === 1'b1) begin
                s16 = 1'b1;
                e = (xv16 === 1'b1) ? pop_w(16) : 'x;
                n_cmp++;
                if (xv16 !== 1'b1 || x16 !== e[15:0]) begin
                    n_bad++;
                    $display("FAIL sweep16 cyc=%0d got v=%b %h want v=1 %h", c, xv16, x16, e[15:0]);
                end
            end
            if (s64 || xv64 === 1'b1) begin
                s64 = 1'b1;
                e = (xv64 === 1'b1) ? pop_w(64) : 'x;
                n_cmp++;
                if (xv64 !== 1'b1 || x64 !== e) begin
                    n_bad++;
                    $display("FAIL sweep64 cyc=%0d got v=%b %h want v=1 %h", c, xv64, x64, e);
                end
            end
        end
        v16 = 1'b0;
        v64 = 1'b0;
        for (int w = 10; w <= 130; w += 60) begin
            sum = 0;
            for (int k = 0; k < 66; k++) sum += int'(acc16[w+k]);
            n_cmp++;
            if (sum != 16) begin
                n_bad++;
                $display("FAIL sweep16_rate start=%0d got %0d want 16", w, sum);
            end
            sum = 0;
            for (int k = 0; k < 66; k++) sum += int'(acc64[w+k]);
            n_cmp++;
            if (sum != 64) begin
                n_bad++;
                $display("FAIL sweep64_rate start=%0d got %0d want 64", w, sum);
            end
        end
    endtask

`ifdef TX_GEARBOX_STATS_EN
    task automatic test_stats();
        int nacc;
        int nuf;
        int guard;
        do_reset();
        nacc  = 0;
        guard = 0;
        v32 = 1'b1;
        while (nacc < 10 && guard < 60) begin
            d32 = {$urandom, $urandom};
            h32 = 2'($urandom_range(0, 3));
            tick();
            guard++;
            if (a32) nacc++;
        end
        v32 = 1'b0;
        nuf   = 0;
        guard = 0;
        while (nuf < 5 && guard < 60) begin
            if (u32 === 1'b1) nuf++;
            if (nuf < 5) tick();
            guard++;
        end
        n_cmp++;
        if (bc32 !== 32'd10 || uc32 !== 16'd5) begin
            n_bad++;
            $display("FAIL stats_counts got blk=%0d uf=%0d want 10/5", bc32, uc32);
        end
        for (int c = 0; c < 65540; c++) tick();
        n_cmp++;
        if (uc32 !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL stats_saturate got %h want ffff", uc32);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        v16 = 1'b0; v32 = 1'b0; v64 = 1'b0;
        d16 = '0;   d32 = '0;   d64 = '0;
        h16 = '0;   h32 = '0;   h64 = '0;
        a16 = 1'b0; a32 = 1'b0; a64 = 1'b0;
        test_reset();
        test_latency();
        test_stream32();
        test_starvation();
        test_reset_mid();
        test_width_sweep();
`ifdef TX_GEARBOX_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
